sys_ctrl_tx_sched: RTL

Response scheduler that shares the single UART transmitter between two result sources: register-file read data (one byte) and ALU results (two bytes, LSB first). Each source gets a one-entry holding slot, so results arriving while the UART is busy are not lost. The block serialises pending results into byte transfers using a valid/busy handshake toward the UART TX. It sits beside the RX command decoder in the system controller, between the RegFile/ALU outputs and UART TX.

---
 rtl/sys_ctrl_pkg.sv | 16 +
 rtl/tx_hold_slot.sv | 39 +++
 rtl/sys_ctrl_tx_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared encodings for the system-controller response path: FSM states and
// result-source identifiers.
package sys_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } tx_state_e;

    localparam logic SRC_REG = 1'b0;
    localparam logic SRC_ALU = 1'b1;

endpackage

// File: rtl/tx_hold_slot.sv
// One-entry holding slot: captures a strobed result when empty (or while being
// popped) and flags a drop when a strobe hits an occupied slot.
module tx_hold_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_strobe,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drop
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_capture;

    // A pop in the same cycle frees the slot, so a concurrent strobe refills it.
    assign w_capture = i_strobe & (~r_full | i_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            r_full <= w_capture | (r_full & ~i_pop);
            if (w_capture) begin
                r_data <= i_data;
            end
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_drop = i_strobe & r_full & ~i_pop;

endmodule

// File: rtl/sys_ctrl_tx_sched.sv
// Shares the UART transmitter between RegFile read data (1 byte) and ALU
// results (2 bytes, LSB first) using per-source holding slots.
module sys_ctrl_tx_sched
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    TX_Busy,
    input  logic                    Err_Clr,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    Ctrl_Busy,
    output logic                    Drop_Err,
    output logic                    Ack_Err
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ACK_MAX  = CNT_W'(ACK_TIMEOUT);

    tx_state_e               r_state, w_state_d;
    logic                    r_src;
    logic                    r_last_src;
    logic [2*DATA_WIDTH-1:0] r_buf;
    logic [1:0]              r_bytes;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_drop_err;
    logic                    r_ack_err;

    logic                    w_reg_full, w_alu_full;
    logic [DATA_WIDTH-1:0]   w_reg_data;
    logic [2*DATA_WIDTH-1:0] w_alu_data;
    logic                    w_reg_drop, w_alu_drop;
    logic                    w_pop_reg, w_pop_alu;
    logic                    w_pick_alu;
    logic                    w_expire;
    logic                    w_more;
    logic                    w_byte_done;
    logic                    w_tx_vld;
    logic                    w_ack_set;

    tx_hold_slot #(
        .WIDTH (DATA_WIDTH)
    ) u_reg_slot (
        .i_clk    (CLK),
        .i_rst    (rst),
        .i_strobe (RdData_Valid),
        .i_data   (RdData),
        .i_pop    (w_pop_reg),
        .o_full   (w_reg_full),
        .o_data   (w_reg_data),
        .o_drop   (w_reg_drop)
    );

    tx_hold_slot #(
        .WIDTH (2 * DATA_WIDTH)
    ) u_alu_slot (
        .i_clk    (CLK),
        .i_rst    (rst),
        .i_strobe (OUT_Valid),
        .i_data   (ALU_OUT),
        .i_pop    (w_pop_alu),
        .o_full   (w_alu_full),
        .o_data   (w_alu_data),
        .o_drop   (w_alu_drop)
    );

    // RegFile wins a tie unless it won the previous transfer.
    assign w_pick_alu = w_alu_full & (~w_reg_full | (r_last_src == SRC_REG));
    assign w_expire   = (r_cnt >= ACK_LAST);
    assign w_more     = (r_bytes > 2'd1);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_tx_vld    = 1'b0;
        w_pop_reg   = 1'b0;
        w_pop_alu   = 1'b0;
        w_byte_done = 1'b0;
        w_ack_set   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_reg_full | w_alu_full) begin
                    w_state_d = LOAD;
                end
            end
            LOAD: begin
                w_pop_reg = (r_src == SRC_REG);
                w_pop_alu = (r_src == SRC_ALU);
                w_state_d = SEND;
            end
            SEND: begin
                if (!TX_Busy) begin
                    w_tx_vld  = 1'b1;
                    w_state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (TX_Busy) begin
                    w_state_d = WAIT_DONE;
                end else if (w_expire) begin
                    w_ack_set   = 1'b1;
                    w_byte_done = 1'b1;
                    w_state_d   = w_more ? SEND : IDLE;
                end
            end
            WAIT_DONE: begin
                if (!TX_Busy) begin
                    w_byte_done = 1'b1;
                    w_state_d   = w_more ? SEND : IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_src      <= SRC_REG;
            r_last_src <= SRC_ALU;
            r_buf      <= '0;
            r_bytes    <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
        end else begin
            if (r_state == IDLE && (w_reg_full | w_alu_full)) begin
                r_src <= w_pick_alu ? SRC_ALU : SRC_REG;
            end
            // TX_P_DATA is loaded on entry to SEND so it is stable for the pulse.
            if (r_state == LOAD) begin
                r_last_src <= r_src;
                if (r_src == SRC_ALU) begin
                    r_buf     <= w_alu_data;
                    r_tx_data <= w_alu_data[DATA_WIDTH-1:0];
                    r_bytes   <= 2'd2;
                end else begin
                    r_buf     <= {{DATA_WIDTH{1'b0}}, w_reg_data};
                    r_tx_data <= w_reg_data;
                    r_bytes   <= 2'd1;
                end
            end
            if (w_tx_vld) begin
                r_cnt <= '0;
            end else if (r_state == WAIT_ACK && !TX_Busy && !w_expire) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_ack_set && r_cnt != ACK_MAX) begin
                r_cnt <= ACK_MAX;
            end
            if (w_byte_done) begin
                r_bytes <= r_bytes - 2'd1;
                if (w_more) begin
                    r_tx_data <= r_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
        end
    end

    // Sticky flags: a set event takes priority over a simultaneous clear.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_drop_err <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            if (w_reg_drop | w_alu_drop) begin
                r_drop_err <= 1'b1;
            end else if (Err_Clr) begin
                r_drop_err <= 1'b0;
            end
            if (w_ack_set) begin
                r_ack_err <= 1'b1;
            end else if (Err_Clr) begin
                r_ack_err <= 1'b0;
            end
        end
    end

    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = w_tx_vld;
    assign Ctrl_Busy = (r_state != IDLE) | w_reg_full | w_alu_full;
    assign Drop_Err  = r_drop_err;
    assign Ack_Err   = r_ack_err;

endmodule
